// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the pipelined MIPS-subset CPU.
//   - Reset and exception vector defaults used by the fetch unit.
//   - fetch_entry_t: one prefetched {instruction, pc} pair.
//   - NOP_INSTR: the word decode sees when no instruction is available.
//   - next_seq_pc(): sequential successor of a fetch PC. It wraps modulo 2^32.
package cpu_pkg;

  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [31:0] ILLOP_VEC_DEF = 32'h8000_0004;
  localparam logic [31:0] XADR_VEC_DEF  = 32'h8000_0008;
  localparam logic [31:0] NOP_INSTR     = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  // Plain 32-bit add: 32'hFFFF_FFFC steps to 32'h0000_0000.
  function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: register-based circular buffer of fetch_entry_t.
//   clk, reset        : clock, asynchronous active-low reset
//   push, push_entry  : write push_entry at the tail this cycle
//   pop               : drop the head entry this cycle
//   flush             : empty the buffer. It overrides push and pop.
//   head_entry        : entry at the read pointer. It is stale when count==0.
//   count             : occupied entries, 0..DEPTH
//   full              : count == DEPTH
// A push is accepted when the buffer is not full, or when a pop frees a slot
// in the same cycle. A pop is accepted only when the buffer is non-empty.
// DEPTH must be a power of two, so the pointers wrap without extra compare logic.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  fetch_entry_t             push_entry,
  input  logic                     pop,
  input  logic                     flush,
  output fetch_entry_t             head_entry,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t      mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       cnt_q;
  logic              pop_ok;
  logic              push_ok;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign pop_ok  = pop && (cnt_q != '0);
  assign push_ok = push && (!full || pop_ok);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset. Slots are only read while count says they hold data.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= push_entry;
  end

  assign head_entry = mem[rd_ptr];
  assign count      = cnt_q;

endmodule

// File: rtl/pipe_fetch_unit.sv
// pipe_fetch_unit: instruction-fetch front end. It has a PC generator and a
// DEPTH-entry prefetch buffer between the instruction ROM and decode.
//   clk, reset         : clock, asynchronous active-low reset
//   imem_addr          : fetch address, which is the current PC
//   imem_data          : instruction word at imem_addr
//   imem_valid         : imem_data is valid this cycle. 0 means a wait state.
//   redir_valid/pc     : branch/jump/jr redirect request and its target
//   exc_illop/exc_xadr : take ILLOP_VEC / XADR_VEC
//   out_valid          : buffer head holds an instruction
//   out_instr/pc/pc4   : head instruction, its PC, and PC+4
//   out_ready          : decode accepts the head this cycle
//   buf_count          : occupied buffer entries
// Handshake: the head transfers on a cycle where out_valid && out_ready.
// out_* depend only on registered state and never on out_ready. A fetch word
// transfers on a cycle where imem_valid is high and the buffer has room, or
// frees room by popping in the same cycle. imem_addr only moves after such a
// transfer or after a flush, so it stays stable across wait states.
// Flush priority is exc_illop > exc_xadr > redir_valid. A flush takes effect
// atomically: the PC is loaded, the buffer empties, and any push or pop in
// that cycle is discarded.
module pipe_fetch_unit
  import cpu_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] ILLOP_VEC = ILLOP_VEC_DEF,
  parameter logic [31:0] XADR_VEC  = XADR_VEC_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [31:0]              imem_addr,
  input  logic [31:0]              imem_data,
  input  logic                     imem_valid,
  input  logic                     redir_valid,
  input  logic [31:0]              redir_pc,
  input  logic                     exc_illop,
  input  logic                     exc_xadr,
  output logic                     out_valid,
  output logic [31:0]              out_instr,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_pc4,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   buf_count
);

  logic [31:0]          pc_q;
  logic [31:0]          pc_d;
  logic [31:0]          target;
  logic                 flush;
  logic                 push;
  logic                 pop;
  logic                 full;
  logic [$clog2(DEPTH):0] count;
  fetch_entry_t         head_entry;
  fetch_entry_t         push_entry;

  // The target is used verbatim. PC[31] comes from the vector or the redirect.
  always_comb begin
    target = redir_pc;
    if (exc_illop)     target = ILLOP_VEC;
    else if (exc_xadr) target = XADR_VEC;
  end

  assign flush = exc_illop || exc_xadr || redir_valid;
  assign pop   = out_valid && out_ready;
  assign push  = !flush && imem_valid && (!full || pop);

  assign push_entry.instr = imem_data;
  assign push_entry.pc    = pc_q;

  always_comb begin
    pc_d = pc_q;
    if (flush)     pc_d = target;
    else if (push) pc_d = next_seq_pc(pc_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (flush),
    .head_entry (head_entry),
    .count      (count),
    .full       (full)
  );

  assign imem_addr = pc_q;
  assign buf_count = count;
  assign out_valid = (count != '0);

  // An empty buffer presents a bubble: nop at pc 0.
  assign out_instr = out_valid ? head_entry.instr : NOP_INSTR;
  assign out_pc    = out_valid ? head_entry.pc    : 32'h0;
  assign out_pc4   = out_pc + 32'd4;

endmodule

// File: tb/tb_pipe_fetch_unit.sv
// tb_pipe_fetch_unit: drives three fetch units (DEPTH 4, 2 and 8) with shared
// control inputs. Each unit gets its own ROM, which is a fixed function of
// its fetch address. Each unit is checked every cycle against a queue-based
// reference model. Directed steps come first, then a randomized run.
module tb_pipe_fetch_unit;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- shared inputs ----------------
  logic        imem_valid;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        exc_illop;
  logic        exc_xadr;
  logic        out_ready;

  // ---------------- per-instance outputs ----------------
  logic [31:0] addr_o  [3];
  logic [31:0] data_i  [3];
  logic        valid_o [3];
  logic [31:0] instr_o [3];
  logic [31:0] pc_o    [3];
  logic [31:0] pc4_o   [3];
  logic [2:0]  bc_d4;
  logic [1:0]  bc_d2;
  logic [3:0]  bc_d8;
  logic [31:0] bc_o    [3];

  int dep [3] = '{4, 2, 8};

  function automatic logic [31:0] rom(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_rom
    assign data_i[g] = rom(addr_o[g]);
  end
  assign bc_o[0] = {29'b0, bc_d4};
  assign bc_o[1] = {30'b0, bc_d2};
  assign bc_o[2] = {28'b0, bc_d8};

  pipe_fetch_unit #(.DEPTH(4)) dut4 (
    .clk(clk), .reset(reset), .imem_addr(addr_o[0]), .imem_data(data_i[0]),
    .imem_valid(imem_valid), .redir_valid(redir_valid), .redir_pc(redir_pc),
    .exc_illop(exc_illop), .exc_xadr(exc_xadr), .out_valid(valid_o[0]),
    .out_instr(instr_o[0]), .out_pc(pc_o[0]), .out_pc4(pc4_o[0]),
    .out_ready(out_ready), .buf_count(bc_d4));

  pipe_fetch_unit #(.DEPTH(2)) dut2 (
    .clk(clk), .reset(reset), .imem_addr(addr_o[1]), .imem_data(data_i[1]),
    .imem_valid(imem_valid), .redir_valid(redir_valid), .redir_pc(redir_pc),
    .exc_illop(exc_illop), .exc_xadr(exc_xadr), .out_valid(valid_o[1]),
    .out_instr(instr_o[1]), .out_pc(pc_o[1]), .out_pc4(pc4_o[1]),
    .out_ready(out_ready), .buf_count(bc_d2));

  pipe_fetch_unit #(.DEPTH(8)) dut8 (
    .clk(clk), .reset(reset), .imem_addr(addr_o[2]), .imem_data(data_i[2]),
    .imem_valid(imem_valid), .redir_valid(redir_valid), .redir_pc(redir_pc),
    .exc_illop(exc_illop), .exc_xadr(exc_xadr), .out_valid(valid_o[2]),
    .out_instr(instr_o[2]), .out_pc(pc_o[2]), .out_pc4(pc4_o[2]),
    .out_ready(out_ready), .buf_count(bc_d8));

  // ---------------- reference model ----------------
  // The model keeps the fetch PC and the ordered list of buffered PCs. The
  // instruction of an entry is always rom(pc) of that instance.
  logic [31:0] m_pc  [3];
  logic [31:0] m_q   [3][16];
  int          m_cnt [3];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_pc[i]  = 32'h0;
      m_cnt[i] = 0;
    end
  endtask

  task automatic check_all();
    logic [31:0] e_pc;
    for (int i = 0; i < 3; i++) begin
      e_pc = (m_cnt[i] != 0) ? m_q[i][0] : 32'h0;
      chk($sformatf("d%0d_addr", dep[i]),  addr_o[i], m_pc[i]);
      chk($sformatf("d%0d_valid", dep[i]), {31'b0, valid_o[i]}, {31'b0, m_cnt[i] != 0});
      chk($sformatf("d%0d_pc", dep[i]),    pc_o[i], e_pc);
      chk($sformatf("d%0d_pc4", dep[i]),   pc4_o[i], e_pc + 32'd4);
      chk($sformatf("d%0d_instr", dep[i]), instr_o[i], (m_cnt[i] != 0) ? rom(e_pc) : 32'h0);
      chk($sformatf("d%0d_count", dep[i]), bc_o[i], 32'(m_cnt[i]));
    end
  endtask

  task automatic model_update();
    logic pop_m;
    logic push_m;
    for (int i = 0; i < 3; i++) begin
      pop_m = (m_cnt[i] > 0) && out_ready;
      if (exc_illop || exc_xadr || redir_valid) begin
        m_pc[i]  = exc_illop ? 32'h8000_0004 : exc_xadr ? 32'h8000_0008 : redir_pc;
        m_cnt[i] = 0;
      end else begin
        push_m = imem_valid && ((m_cnt[i] < dep[i]) || pop_m);
        if (pop_m) begin
          for (int k = 0; k < 15; k++) m_q[i][k] = m_q[i][k+1];
          m_cnt[i]--;
        end
        if (push_m) begin
          m_q[i][m_cnt[i]] = m_pc[i];
          m_cnt[i]++;
          m_pc[i] = m_pc[i] + 32'd4;
        end
      end
    end
  endtask

  // ---------------- driver ----------------
  // This is called about 1 time unit after a rising edge. It checks the
  // current state, advances the model with the inputs now applied, and then
  // moves past the next edge.
  task automatic step();
    check_all();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic iv, input logic rdy, input logic rv,
                        input logic [31:0] rpc, input logic ei, input logic ex);
    imem_valid  = iv;
    out_ready   = rdy;
    redir_valid = rv;
    redir_pc    = rpc;
    exc_illop   = ei;
    exc_xadr    = ex;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    model_reset();
    check_all();
    chk("rst_pc4", pc4_o[0], 32'h4);
    chk("rst_instr", instr_o[0], 32'h0);
    reset = 1'b1;

    // Fill with decode stalled.
    set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int n = 0; n < 5; n++) step();
    chk("fill_count", bc_o[0], 32'd4);
    chk("fill_addr", addr_o[0], 32'h10);
    chk("fill_head", pc_o[0], 32'h0);

    // Full buffer with one push and one pop per cycle.
    out_ready = 1'b1;
    for (int n = 0; n < 4; n++) step();
    chk("stream_count", bc_o[0], 32'd4);
    chk("stream_head", pc_o[0], 32'h10);

    // Wait states at PC 0x20.
    set_in(1'b1, 1'b1, 1'b1, 32'h20, 1'b0, 1'b0);
    step();
    set_in(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    step();
    chk("ws_addr0", addr_o[0], 32'h24);
    imem_valid = 1'b0;
    step();
    chk("ws_addr1", addr_o[0], 32'h24);
    step();
    chk("ws_addr2", addr_o[0], 32'h24);
    imem_valid = 1'b1;
    step();
    step();

    // Redirect with 3 entries buffered.
    set_in(1'b1, 1'b0, 1'b1, 32'h200, 1'b0, 1'b0);
    step();
    redir_valid = 1'b0;
    for (int n = 0; n < 3; n++) step();
    chk("pre_redir_count", bc_o[0], 32'd3);
    set_in(1'b1, 1'b1, 1'b1, 32'h100, 1'b0, 1'b0);
    step();
    chk("redir_count", bc_o[0], 32'd0);
    chk("redir_valid", {31'b0, valid_o[0]}, 32'd0);
    chk("redir_addr", addr_o[0], 32'h100);
    redir_valid = 1'b0;
    step();
    chk("redir_head_pc", pc_o[0], 32'h100);
    chk("redir_head_pc4", pc4_o[0], 32'h104);

    // Priority: all three asserted, then the interrupt vector alone.
    set_in(1'b1, 1'b1, 1'b1, 32'h300, 1'b1, 1'b1);
    step();
    chk("prio_illop", addr_o[0], 32'h8000_0004);
    set_in(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    step();
    chk("prio_xadr", addr_o[0], 32'h8000_0008);

    // Wrap at the top of the address space.
    set_in(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
    step();
    redir_valid = 1'b0;
    step();
    chk("wrap_addr", addr_o[0], 32'h0);
    chk("wrap_head", pc_o[0], 32'hFFFF_FFFC);

    // Asynchronous reset mid-fill.
    out_ready = 1'b0;
    step();
    step();
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
    #1;
    reset = 1'b1;
    step();

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      imem_valid  = ($urandom_range(0, 3) != 0);
      out_ready   = ($urandom_range(0, 3) != 0);
      redir_valid = ($urandom_range(0, 15) == 0);
      redir_pc    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
      exc_illop   = ($urandom_range(0, 31) == 0);
      exc_xadr    = ($urandom_range(0, 31) == 0);
      step();
    end
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
